// File: rtl/reg_file_wb_if.sv
// Write-back / decode-side bundle of the RV32I integer register file.
// master = pipeline stages driving WB and ID, slave = the register file.
interface reg_file_wb_if #(
    parameter int XLEN = 32
);
    logic [4:0]      WB_rd_i;
    logic            WB_Reg_writeE_i;
    logic [XLEN-1:0] WB_wr_data_i;
    logic            WB_is_load_i;
    logic [4:0]      ID_rs1_i;
    logic [4:0]      ID_rs2_i;
    logic            ID_ld_issue_i;
    logic [4:0]      ID_ld_rd_i;
    logic [XLEN-1:0] ID_rs1_data_o;
    logic [XLEN-1:0] ID_rs2_data_o;
    logic            ID_stall_o;

    modport master (
        output WB_rd_i, WB_Reg_writeE_i, WB_wr_data_i, WB_is_load_i,
        output ID_rs1_i, ID_rs2_i, ID_ld_issue_i, ID_ld_rd_i,
        input  ID_rs1_data_o, ID_rs2_data_o, ID_stall_o
    );

    modport slave (
        input  WB_rd_i, WB_Reg_writeE_i, WB_wr_data_i, WB_is_load_i,
        input  ID_rs1_i, ID_rs2_i, ID_ld_issue_i, ID_ld_rd_i,
        output ID_rs1_data_o, ID_rs2_data_o, ID_stall_o
    );
endinterface

// File: rtl/reg_file_wb.sv
// RV32I integer register file: WB write sink, two bypassed read ports for ID,
// and a per-register load scoreboard that raises a load-use stall.
module reg_file_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic          clk_i,
    input logic          rst_n_i,
    reg_file_wb_if.slave bus
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic wb_write;
    logic wb_load_clr;
    logic pend1;
    logic pend2;

    assign wb_write    = bus.WB_Reg_writeE_i && (bus.WB_rd_i != 5'd0);
    assign wb_load_clr = wb_write && bus.WB_is_load_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[bus.WB_rd_i] <= bus.WB_wr_data_i;
        end
    end

    // Set is applied after clear so a younger load to the same rd keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_load_clr) begin
            busy_nxt[bus.WB_rd_i] = 1'b0;
        end
        if (bus.ID_ld_issue_i && (bus.ID_ld_rd_i != 5'd0)) begin
            busy_nxt[bus.ID_ld_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        if (bus.ID_rs1_i == 5'd0) begin
            bus.ID_rs1_data_o = '0;
        end else if (wb_write && (bus.WB_rd_i == bus.ID_rs1_i)) begin
            bus.ID_rs1_data_o = bus.WB_wr_data_i;
        end else begin
            bus.ID_rs1_data_o = regs[bus.ID_rs1_i];
        end
    end

    always_comb begin
        if (bus.ID_rs2_i == 5'd0) begin
            bus.ID_rs2_data_o = '0;
        end else if (wb_write && (bus.WB_rd_i == bus.ID_rs2_i)) begin
            bus.ID_rs2_data_o = bus.WB_wr_data_i;
        end else begin
            bus.ID_rs2_data_o = regs[bus.ID_rs2_i];
        end
    end

    // A load writing back this cycle is served by the bypass, so it does not stall.
    assign pend1 = busy[bus.ID_rs1_i] && (bus.ID_rs1_i != 5'd0)
                   && !(wb_load_clr && (bus.WB_rd_i == bus.ID_rs1_i));
    assign pend2 = busy[bus.ID_rs2_i] && (bus.ID_rs2_i != 5'd0)
                   && !(wb_load_clr && (bus.WB_rd_i == bus.ID_rs2_i));

    assign bus.ID_stall_o = pend1 | pend2;
endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed vector table, reset-during-load sequence,
// then randomized traffic against an array-based reference model.
module tb_reg_file_wb;
    logic clk_i = 1'b0;
    logic rst_n_i;

    reg_file_wb_if #(.XLEN(32)) bus ();

    reg_file_wb #(.XLEN(32), .NREGS(32)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        is_load;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ld_issue;
        logic [4:0]  ld_rd;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic vec_t mk(logic wr, logic [4:0] rd, logic [31:0] wdata, logic is_load,
                                logic [4:0] rs1, logic [4:0] rs2, logic ld_issue,
                                logic [4:0] ld_rd, logic [31:0] e1, logic [31:0] e2,
                                logic es);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wdata = wdata; v.is_load = is_load;
        v.rs1 = rs1; v.rs2 = rs2; v.ld_issue = ld_issue; v.ld_rd = ld_rd;
        v.exp_rs1 = e1; v.exp_rs2 = e2; v.exp_stall = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.WB_Reg_writeE_i = v.wr;
        bus.WB_rd_i         = v.rd;
        bus.WB_wr_data_i    = v.wdata;
        bus.WB_is_load_i    = v.is_load;
        bus.ID_rs1_i        = v.rs1;
        bus.ID_rs2_i        = v.rs2;
        bus.ID_ld_issue_i   = v.ld_issue;
        bus.ID_ld_rd_i      = v.ld_rd;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] e1, e2;
        logic        es;

        // wr rd wdata load | rs1 rs2 | issue ld_rd | exp1 exp2 stall
        vecs.push_back(mk(0, 0,  32'h0,        0, 1,  31, 0, 0,  32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 5,  0,  0, 0,  32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 5,  5,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0,  32'h12345678, 0, 0,  0,  0, 0,  32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 0,  32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 7,  32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  7,  0, 0,  32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  7,  0, 0,  32'h0,        32'h0,        1));
        vecs.push_back(mk(1, 7,  32'hA5A5A5A5, 1, 0,  7,  0, 0,  32'h0,        32'hA5A5A5A5, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  7,  0, 0,  32'h0,        32'hA5A5A5A5, 0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 9,  32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 9,  32'h11111111, 1, 9,  0,  1, 9,  32'h11111111, 32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 9,  0,  0, 0,  32'h11111111, 32'h0,        1));
        vecs.push_back(mk(1, 9,  32'h22222222, 1, 9,  0,  0, 0,  32'h22222222, 32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 9,  0,  0, 0,  32'h22222222, 32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 12, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 12, 32'h00000033, 0, 12, 0,  0, 0,  32'h00000033, 32'h0,        1));
        vecs.push_back(mk(1, 12, 32'h00000044, 1, 0,  12, 0, 0,  32'h0,        32'h00000044, 0));
        vecs.push_back(mk(1, 20, 32'h00000055, 0, 20, 20, 0, 0,  32'h00000055, 32'h00000055, 0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 12, 0,  1, 0,  32'h00000044, 32'h0,        0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 0,  32'h0,        32'h0,        0));

        do_reset();
        #2;
        for (int r = 1; r < 32; r++) begin
            bus.ID_rs1_i = 5'(r);
            bus.ID_rs2_i = 5'(32 - r);
            #1;
            check("reset_rs1", bus.ID_rs1_data_o, 32'h0);
            check("reset_rs2", bus.ID_rs2_data_o, 32'h0);
            check("reset_stall", {31'h0, bus.ID_stall_o}, 32'h0);
        end

        foreach (vecs[i]) begin
            @(posedge clk_i);
            #2 drive(vecs[i]);
            #2;
            check($sformatf("vec%0d_rs1", i), bus.ID_rs1_data_o, vecs[i].exp_rs1);
            check($sformatf("vec%0d_rs2", i), bus.ID_rs2_data_o, vecs[i].exp_rs2);
            check($sformatf("vec%0d_stall", i), {31'h0, bus.ID_stall_o}, {31'h0, vecs[i].exp_stall});
        end

        // Loads pending on x3 and x4, then reset in the middle of a cycle.
        @(posedge clk_i);
        #2 drive(mk(1, 3, 32'hCAFE0003, 0, 0, 0, 1, 3, 0, 0, 0));
        @(posedge clk_i);
        #2 drive(mk(1, 4, 32'hCAFE0004, 0, 0, 0, 1, 4, 0, 0, 0));
        @(posedge clk_i);
        #2 drive(mk(0, 0, 32'h0, 0, 3, 4, 0, 0, 0, 0, 0));
        #1;
        check("rst_pre_stall", {31'h0, bus.ID_stall_o}, 32'h1);
        check("rst_pre_rs1", bus.ID_rs1_data_o, 32'hCAFE0003);
        #1 rst_n_i = 1'b0;
        #1;
        check("rst_mid_stall", {31'h0, bus.ID_stall_o}, 32'h0);
        check("rst_mid_rs1", bus.ID_rs1_data_o, 32'h0);
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        #1;
        check("rst_post_rs1", bus.ID_rs1_data_o, 32'h0);
        check("rst_post_stall", {31'h0, bus.ID_stall_o}, 32'h0);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            @(posedge clk_i);
            #2;
            v.wr       = 1'($urandom_range(0, 1));
            v.rd       = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            v.wdata    = $urandom;
            v.is_load  = 1'($urandom_range(0, 1));
            v.rs1      = 5'($urandom_range(0, 7));
            v.rs2      = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            v.ld_rd    = 5'($urandom_range(0, 7));

            e1 = (v.rs1 == 0) ? 32'h0 : (v.wr && v.rd == v.rs1) ? v.wdata : m_regs[v.rs1];
            e2 = (v.rs2 == 0) ? 32'h0 : (v.wr && v.rd == v.rs2) ? v.wdata : m_regs[v.rs2];
            es = (v.rs1 != 0 && m_busy[v.rs1] && !(v.wr && v.is_load && v.rd == v.rs1)) ||
                 (v.rs2 != 0 && m_busy[v.rs2] && !(v.wr && v.is_load && v.rd == v.rs2));
            v.ld_issue = !es && ($urandom_range(0, 2) == 0);
            drive(v);
            #2;
            check("rand_rs1", bus.ID_rs1_data_o, e1);
            check("rand_rs2", bus.ID_rs2_data_o, e2);
            check("rand_stall", {31'h0, bus.ID_stall_o}, {31'h0, es});

            if (v.wr && v.rd != 0) m_regs[v.rd] = v.wdata;
            if (v.wr && v.is_load && v.rd != 0) m_busy[v.rd] = 1'b0;
            if (v.ld_issue && v.ld_rd != 0) m_busy[v.ld_rd] = 1'b1;
        end

        @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
